dnu_signexten_pingpong_ram: RTL
===============================

Name: dnu_signexten_pingpong_ram

Overview:
Double-buffered (ping-pong) sign-extension staging memory between the sign-extension unit and the DNU input stage of the layered decoder.
- Write side fills one bank row-chunk by row-chunk with an auto-incrementing address.
- Read side consumes the other, completed bank at arbitrary row addresses.
- Bank ownership is handed over with valid/ready and release handshakes, so the decoder overlaps the next layer's fill with the current layer's DNU reads.
- Single clock domain, write_clk.

Parameters:
- ROW_CHUNK_NUM, 9, row chunks per layer (rows per bank).
- CHECK_PARALLELISM, 85, check nodes per row chunk.
- DEPTH, ROW_CHUNK_NUM, rows per bank.
- DATA_WIDTH, CHECK_PARALLELISM, bits per row.
- ADDR_WIDTH, $clog2(DEPTH), row address width.
- BANK_NUM, 2, fixed at 2; any other value is a compile-time error.

Ports:
- write_clk  in  1  sole clock.
- rstn  in  1  synchronous, active-low reset.
- wr_valid  in  1  write beat present.
- wr_ready  out  1  write bank has a free row.
- signExten_din  in  DATA_WIDTH  write data.
- rd_en  in  1  read request for rd_addr in the read bank.
- rd_addr  in  ADDR_WIDTH  row address within the read bank.
- rd_release  in  1  reader is finished with the read bank.
- mem_to_dnuIn  out  DATA_WIDTH  registered read data.
- rd_dvalid  out  1  mem_to_dnuIn valid this cycle.
- rd_bank_ready  out  1  a completed bank is owned by the reader.
- bank_full  out  2  per-bank completed flag.
- ovf_err  out  1  sticky: rd_en or rd_release issued with rd_bank_ready=0.

Behaviour:
- Reset (rstn=0 at a write_clk edge):
  - wr_ptr=0 (write bank), rd_ptr=0 (read bank), wr_row=0.
  - bank_full=2'b00, mem_to_dnuIn=0, rd_dvalid=0, ovf_err=0.
  - RAM contents are not reset.
  - Reset mid-fill or mid-read abandons all contents; no partial bank is ever reported.
- Write side:
  - wr_ready = ~bank_full[wr_ptr].
  - A beat is accepted when wr_valid & wr_ready; signExten_din is written to bank wr_ptr, row wr_row.
  - After an accepted beat, wr_row increments. When wr_row == DEPTH-1, the accepted beat is the last one:
    - wr_row wraps to 0;
    - bank_full[wr_ptr] is set;
    - wr_ptr toggles.
  - A beat with wr_valid & ~wr_ready is ignored; the writer must hold it.
- Read side:
  - rd_bank_ready = bank_full[rd_ptr].
  - rd_en with rd_bank_ready: mem_to_dnuIn takes bank rd_ptr, row rd_addr at the next edge, and rd_dvalid=1 that cycle. Latency is exactly 1; back-to-back reads give one result per cycle.
  - rd_en without rd_bank_ready: mem_to_dnuIn holds, rd_dvalid=0, ovf_err is set.
  - rd_addr >= DEPTH returns an undefined value; the bench must not check it.
  - rd_release with rd_bank_ready clears bank_full[rd_ptr] and toggles rd_ptr at the next edge.
  - rd_en in the same cycle as rd_release still reads the bank being released.
- Simultaneous events:
  - The last write completing bank X and a release of bank Y in the same cycle both take effect; bank_full is updated per bit.
  - When both banks are full, wr_ready=0 until a release. wr_ready rises the cycle after release.
- No write-to-read bypass. A bank cannot be read until it is full, so there is no read-during-write hazard on the same row.
- State per bank: EMPTY → FILLING (wr_ptr points at it, wr_row > 0) → FULL → (release) → EMPTY.

Optional Feature:
- Macro: DNU_SIGNEXT_PARITY_EN.
- Enabled:
  - Each row stores an extra even-parity bit computed on write.
  - On read, parity is recomputed against the stored bit.
  - Adds output par_err (1 bit), registered alongside rd_dvalid; it pulses high when a parity mismatch is detected.
  - Reset value of par_err is 0.
- Disabled: no par_err port, and RAM width is exactly DATA_WIDTH.

Decomposition:
- Package dnu_ram_pkg:
  - bank-state enum (EMPTY/FILLING/FULL) for bench visibility;
  - localparam BANK_NUM=2;
  - parity function.
- Sub-module dnu_ram_bank: one simple dual-port bank (sync write, async read index, DEPTH × (DATA_WIDTH[+1])).
- Instantiate dnu_ram_bank twice. The top level holds pointers, counters, flags and the output register.

Test Plan:
- Reset, then 9 beats 0x1..0x9 → bank_full=01, wr_ptr=1. rd_en with rd_addr=4 → mem_to_dnuIn=0x5 one cycle later with rd_dvalid=1.
- Fill both banks (18 beats), no release → wr_ready=0. Beat 19 is held off. Release → wr_ready=1 the next cycle, and beat 19 lands in bank 0, row 0.
- Row 8 written into bank 1 (its last write) in the same cycle as rd_release of bank 0 → bank_full=10 afterwards, rd_ptr=1, wr_ptr=0.
- rd_en before any bank is full → rd_dvalid=0, mem_to_dnuIn=0, ovf_err=1 sticky until reset.
- Assert rstn=0 after 5 beats, then resume → rd_bank_ready stays 0 until 9 new beats; the first read returns the post-reset data.
- With DNU_SIGNEXT_PARITY_EN, force-flip one stored bit of row 2, then read row 2 → par_err=1 for one cycle; reads of other rows give par_err=0.

Source files
------------

// File: rtl/dnu_ram_pkg.sv
// Shared types and helpers for the DNU sign-extension ping-pong RAM.
// Optional row parity is enabled with DNU_SIGNEXT_PARITY_EN.
package dnu_ram_pkg;

    localparam int BANK_NUM  = 2;
    localparam int PAR_MAX_W = 1024;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_e;

    // Even-parity bit: callers zero-extend their data to PAR_MAX_W.
    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/dnu_signexten_pingpong_ram_bank.sv
// One simple dual-port bank: synchronous write, asynchronous read index.
module dnu_ram_bank #(
    parameter int DEPTH      = 9,
    parameter int WIDTH      = 85,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  write_clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge write_clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dnu_signexten_pingpong_ram.sv
// Ping-pong staging RAM between sign-extension and the DNU input stage.
// Define DNU_SIGNEXT_PARITY_EN to store a parity bit per row and add par_err.
module dnu_signexten_pingpong_ram #(
    parameter int ROW_CHUNK_NUM     = 9,
    parameter int CHECK_PARALLELISM = 85,
    parameter int DEPTH             = ROW_CHUNK_NUM,
    parameter int DATA_WIDTH        = CHECK_PARALLELISM,
    parameter int ADDR_WIDTH        = $clog2(DEPTH),
    parameter int BANK_NUM          = 2
) (
    input  logic                  write_clk,
    input  logic                  rstn,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] signExten_din,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  rd_release,
    output logic [DATA_WIDTH-1:0] mem_to_dnuIn,
    output logic                  rd_dvalid,
    output logic                  rd_bank_ready,
    output logic [1:0]            bank_full,
`ifdef DNU_SIGNEXT_PARITY_EN
    output logic                  par_err,
`endif
    output logic                  ovf_err
);

    import dnu_ram_pkg::*;

    if (BANK_NUM != dnu_ram_pkg::BANK_NUM) begin : g_bad_bank_num
        $error("dnu_signexten_pingpong_ram: BANK_NUM must be 2");
    end

`ifdef DNU_SIGNEXT_PARITY_EN
    localparam int RAM_W = DATA_WIDTH + 1;
`else
    localparam int RAM_W = DATA_WIDTH;
`endif

    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH-1:0] wr_row_q, wr_row_d;
    logic [1:0]            bank_full_q, bank_full_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  rd_dvalid_q, rd_dvalid_d;
    logic                  ovf_err_q, ovf_err_d;
    logic                  wr_fire, wr_last, rd_fire, rel_fire;
    logic [RAM_W-1:0]      wr_word;
    logic [RAM_W-1:0]      rd_word;
    logic [1:0][RAM_W-1:0] bank_rdata;

    assign wr_ready      = ~bank_full_q[wr_ptr_q];
    assign rd_bank_ready = bank_full_q[rd_ptr_q];
    assign wr_fire       = wr_valid & wr_ready;
    assign wr_last       = wr_fire & (wr_row_q == ADDR_WIDTH'(DEPTH - 1));
    assign rd_fire       = rd_en & rd_bank_ready;
    assign rel_fire      = rd_release & rd_bank_ready;

`ifdef DNU_SIGNEXT_PARITY_EN
    assign wr_word = {even_parity(PAR_MAX_W'(signExten_din)), signExten_din};
`else
    assign wr_word = signExten_din;
`endif

    for (genvar i = 0; i < 2; i++) begin : g_bank
        dnu_ram_bank #(
            .DEPTH      (DEPTH),
            .WIDTH      (RAM_W),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_bank (
            .write_clk (write_clk),
            .we        (wr_fire & (wr_ptr_q == 1'(i))),
            .waddr     (wr_row_q),
            .wdata     (wr_word),
            .raddr     (rd_addr),
            .rdata     (bank_rdata[i])
        );
    end

    assign rd_word = bank_rdata[rd_ptr_q];

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        wr_row_d    = wr_row_q;
        bank_full_d = bank_full_q;
        dout_d      = dout_q;
        rd_dvalid_d = rd_fire;
        ovf_err_d   = ovf_err_q | ((rd_en | rd_release) & ~rd_bank_ready);

        if (wr_fire) begin
            wr_row_d = wr_row_q + 1'b1;
        end
        // Write bank is never full while written, so set/clear hit different bits.
        if (wr_last) begin
            wr_row_d              = '0;
            bank_full_d[wr_ptr_q] = 1'b1;
            wr_ptr_d              = ~wr_ptr_q;
        end
        if (rel_fire) begin
            bank_full_d[rd_ptr_q] = 1'b0;
            rd_ptr_d              = ~rd_ptr_q;
        end
        if (rd_fire) begin
            dout_d = rd_word[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge write_clk) begin
        if (!rstn) begin
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            wr_row_q    <= '0;
            bank_full_q <= 2'b00;
            dout_q      <= '0;
            rd_dvalid_q <= 1'b0;
            ovf_err_q   <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_row_q    <= wr_row_d;
            bank_full_q <= bank_full_d;
            dout_q      <= dout_d;
            rd_dvalid_q <= rd_dvalid_d;
            ovf_err_q   <= ovf_err_d;
        end
    end

`ifdef DNU_SIGNEXT_PARITY_EN
    logic par_err_q, par_err_d;

    always_comb begin
        par_err_d = 1'b0;
        if (rd_fire) begin
            par_err_d = even_parity(PAR_MAX_W'(rd_word[DATA_WIDTH-1:0])) != rd_word[DATA_WIDTH];
        end
    end

    always_ff @(posedge write_clk) begin
        if (!rstn) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
        end
    end

    assign par_err = par_err_q;
`endif

    assign bank_full    = bank_full_q;
    assign mem_to_dnuIn = dout_q;
    assign rd_dvalid    = rd_dvalid_q;
    assign ovf_err      = ovf_err_q;

endmodule
